// File: rtl/project_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : project_io_pkg
// Description : Shared types and defaults for the caravel user-IO sequencer.
//               Sequencer state enum, default bus geometry and the encoding
//               of the "no pending target" flag.
// Revision    : 1.0 - initial release
// ============================================================================
package project_io_pkg;

    localparam int c_DEF_NUM_PROJ = 8;
    localparam int c_DEF_IO_W     = 38;
    localparam int c_DEF_GUARD    = 4;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ARM   = 2'd2,
        ST_RUN   = 2'd3
    } seq_state_t;

    // Target-valid flag: a drain that ends with TARGET_NONE falls back to OFF.
    localparam logic TARGET_NONE = 1'b0;
    localparam logic TARGET_SET  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/io_bus_mux.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_mux
// Description : Combinational NUM_PROJ:1 selector of IO_W-wide slices.
//               Slice p occupies i_bus[p*IO_W +: IO_W]. A select value with
//               no matching slice yields all zeros.
// Ports       : i_bus  - packed project buses
//               i_sel  - slice index
//               o_data - selected slice
// Revision    : 1.0 - initial release
// ============================================================================
module io_bus_mux
    import project_io_pkg::*;
#(
    parameter int NUM_PROJ = c_DEF_NUM_PROJ,
    parameter int IO_W     = c_DEF_IO_W,
    parameter int SEL_W    = $clog2(NUM_PROJ)
)(
    input  logic [NUM_PROJ*IO_W-1:0] i_bus,
    input  logic [SEL_W-1:0]         i_sel,
    output logic [IO_W-1:0]          o_data
);

    always_comb begin
        o_data = '0;
        for (int p = 0; p < NUM_PROJ; p++) begin
            if (i_sel == SEL_W'(p)) begin
                o_data = i_bus[p*IO_W +: IO_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/project_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : project_io_sequencer
// Description : Owns the shared user IO pads and hands them to at most one
//               wrapped project at a time. Ownership changes pass through a
//               DRAIN interval (everything off, pads tri-stated) and an ARM
//               interval (new project enabled, pads still gated), each GUARD
//               cycles long, so two projects never drive the pads together.
// Ports       : wb_clk_i / wb_rst_n         - clock, async active-low reset
//               sel_i / sel_valid_i          - switch request (sel_ready_o)
//               disable_i                    - turn every project off
//               proj_io_out_i / proj_io_oeb_i- packed project pad buses
//               active_o                     - one-hot (or zero) enables
//               io_out / io_oeb              - registered pad drive
//               cur_sel_o / cur_valid_o      - current owner, valid in RUN
//               err_o                        - out-of-range request pulse
//               switch_cnt_o                 - completed switches (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module project_io_sequencer
    import project_io_pkg::*;
#(
    parameter int NUM_PROJ = c_DEF_NUM_PROJ,
    parameter int IO_W     = c_DEF_IO_W,
    parameter int GUARD    = c_DEF_GUARD,
    parameter int SEL_W    = $clog2(NUM_PROJ)
)(
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n,
    input  logic [SEL_W-1:0]         sel_i,
    input  logic                     sel_valid_i,
    output logic                     sel_ready_o,
    input  logic                     disable_i,
    input  logic [NUM_PROJ*IO_W-1:0] proj_io_out_i,
    input  logic [NUM_PROJ*IO_W-1:0] proj_io_oeb_i,
    output logic [NUM_PROJ-1:0]      active_o,
    output logic [IO_W-1:0]          io_out,
    output logic [IO_W-1:0]          io_oeb,
    output logic [SEL_W-1:0]         cur_sel_o,
    output logic                     cur_valid_o,
    output logic                     err_o,
    output logic [7:0]               switch_cnt_o
);

    localparam int                 CNT_W        = $clog2(GUARD + 1);
    localparam logic [CNT_W-1:0]   c_GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [SEL_W:0]     c_NUM_PROJ   = (SEL_W + 1)'(NUM_PROJ);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    seq_state_t            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_tgt_vld;
    logic [SEL_W-1:0]      r_tgt_sel;

    logic [NUM_PROJ-1:0]   r_active;
    logic [IO_W-1:0]       r_io_out;
    logic [IO_W-1:0]       r_io_oeb;
    logic [SEL_W-1:0]      r_cur_sel;
    logic                  r_cur_valid;
    logic                  r_err;
    logic [7:0]            r_switch_cnt;
    logic                  r_sel_ready;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    seq_state_t            w_next_state;
    logic                  w_next_tgt_vld;
    logic [SEL_W-1:0]      w_next_tgt_sel;
    logic                  w_sel_in_range;
    logic                  w_req;
    logic                  w_accept;
    logic                  w_guard_done;
    logic [IO_W-1:0]       w_mux_out;
    logic [IO_W-1:0]       w_mux_oeb;

    logic [NUM_PROJ-1:0]   w_active_next;
    logic [IO_W-1:0]       w_io_out_next;
    logic [IO_W-1:0]       w_io_oeb_next;
    logic [SEL_W-1:0]      w_cur_sel_next;
    logic                  w_run_entry;

    assign w_sel_in_range = ({1'b0, sel_i} < c_NUM_PROJ);
    assign w_req          = sel_valid_i & r_sel_ready;
    assign w_accept       = w_req & w_sel_in_range;
    assign w_guard_done   = (r_cnt == c_GUARD_LAST);

    // Pad path is mux-then-register; the mux always follows the owner.
    io_bus_mux #(
        .NUM_PROJ (NUM_PROJ),
        .IO_W     (IO_W),
        .SEL_W    (SEL_W)
    ) u_mux_out (
        .i_bus    (proj_io_out_i),
        .i_sel    (r_cur_sel),
        .o_data   (w_mux_out)
    );

    io_bus_mux #(
        .NUM_PROJ (NUM_PROJ),
        .IO_W     (IO_W),
        .SEL_W    (SEL_W)
    ) u_mux_oeb (
        .i_bus    (proj_io_oeb_i),
        .i_sel    (r_cur_sel),
        .o_data   (w_mux_oeb)
    );

    // ------------------------------------------------------------------
    // State register, guard counter and pending target
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state   <= ST_OFF;
            r_cnt     <= '0;
            r_tgt_vld <= TARGET_NONE;
            r_tgt_sel <= '0;
        end else begin
            r_state   <= w_next_state;
            r_tgt_vld <= w_next_tgt_vld;
            r_tgt_sel <= w_next_tgt_sel;
            // Any state change (including ARM->DRAIN) restarts the guard.
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == ST_DRAIN) || (r_state == ST_ARM)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_next_tgt_vld = r_tgt_vld;
        w_next_tgt_sel = r_tgt_sel;
        case (r_state)
            ST_OFF: begin
                // Pads are already quiet, so go straight to ARM.
                if (w_accept) begin
                    w_next_tgt_vld = TARGET_SET;
                    w_next_tgt_sel = sel_i;
                    w_next_state   = ST_ARM;
                end
            end
            ST_RUN: begin
                // In RUN the target mirrors the owner, so a repeat select
                // of the owner changes nothing.
                if (disable_i) begin
                    w_next_tgt_vld = TARGET_NONE;
                    w_next_state   = ST_DRAIN;
                end else if (w_accept && (sel_i != r_cur_sel)) begin
                    w_next_tgt_vld = TARGET_SET;
                    w_next_tgt_sel = sel_i;
                    w_next_state   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_guard_done) begin
                    w_next_state = (r_tgt_vld == TARGET_SET) ? ST_ARM : ST_OFF;
                end
            end
            ST_ARM: begin
                if (disable_i) begin
                    w_next_tgt_vld = TARGET_NONE;
                    w_next_state   = ST_DRAIN;
                end else if (w_guard_done) begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_OFF;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        w_run_entry    = (r_state == ST_ARM) && (w_next_state == ST_RUN);
        w_cur_sel_next = w_run_entry ? r_tgt_sel : r_cur_sel;

        w_active_next = '0;
        for (int p = 0; p < NUM_PROJ; p++) begin
            w_active_next[p] = ((w_next_state == ST_ARM) || (w_next_state == ST_RUN))
                               && (w_next_tgt_sel == SEL_W'(p));
        end

        // Only forward project data while ownership is stable across the
        // edge; the first RUN cycle and any exit from RUN stay gated.
        if ((r_state == ST_RUN) && (w_next_state == ST_RUN)) begin
            w_io_out_next = w_mux_out;
            w_io_oeb_next = w_mux_oeb;
        end else begin
            w_io_out_next = '0;
            w_io_oeb_next = '1;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_active     <= '0;
            r_io_out     <= '0;
            r_io_oeb     <= '1;
            r_cur_sel    <= '0;
            r_cur_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_switch_cnt <= '0;
            r_sel_ready  <= 1'b1;
        end else begin
            r_active     <= w_active_next;
            r_io_out     <= w_io_out_next;
            r_io_oeb     <= w_io_oeb_next;
            r_cur_sel    <= w_cur_sel_next;
            r_cur_valid  <= (w_next_state == ST_RUN);
            r_err        <= w_req & ~w_sel_in_range;
            r_sel_ready  <= (w_next_state == ST_OFF) || (w_next_state == ST_RUN);
            if (w_run_entry) begin
                r_switch_cnt <= r_switch_cnt + 8'd1;
            end
        end
    end

    assign sel_ready_o  = r_sel_ready;
    assign active_o     = r_active;
    assign io_out       = r_io_out;
    assign io_oeb       = r_io_oeb;
    assign cur_sel_o    = r_cur_sel;
    assign cur_valid_o  = r_cur_valid;
    assign err_o        = r_err;
    assign switch_cnt_o = r_switch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_project_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_project_io_sequencer
// Description : Self-checking bench for project_io_sequencer. A schedule
//               based reference model (drain/arm end times, owner, target)
//               predicts every output after each clock edge. A second,
//               6-project instance exercises out-of-range requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_project_io_sequencer;

    localparam int NP    = 8;
    localparam int IOW   = 38;
    localparam int G     = 4;
    localparam int SW    = 3;
    localparam int ALL_W = NP + 2*IOW + SW + 11;
    localparam int NPE   = 6;
    localparam int IOWE  = 8;
    localparam int GE    = 2;
    localparam int SWE   = 3;
    localparam int M_OFF = 0, M_DRAIN = 1, M_ARM = 2, M_RUN = 3;
    localparam logic [IOW-1:0] PAT2 = 38'h15555;
    localparam logic [IOW-1:0] PAT5 = 38'h2AAAAAAAAA;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [SW-1:0]     sel_i;
    logic              sel_valid_i, disable_i;
    logic [NP*IOW-1:0] proj_out, proj_oeb;
    logic              sel_ready_o, cur_valid_o, err_o;
    logic [NP-1:0]     active_o;
    logic [IOW-1:0]    io_out, io_oeb;
    logic [SW-1:0]     cur_sel_o;
    logic [7:0]        switch_cnt_o;

    logic [SWE-1:0]       e_sel;
    logic                 e_valid, e_ready, e_cur_valid, e_err;
    logic [NPE*IOWE-1:0]  e_pout, e_poeb;
    logic [NPE-1:0]       e_active;
    logic [IOWE-1:0]      e_io_out, e_io_oeb;
    logic [SWE-1:0]       e_cur_sel;
    logic [7:0]           e_cnt;

    logic [ALL_W-1:0] obs_all, x_all;
    assign obs_all = {active_o, io_out, io_oeb, cur_sel_o, cur_valid_o, err_o, switch_cnt_o, sel_ready_o};

    int n_vec = 0, n_bad = 0;
    int m_e, m_drain_until, m_arm_until, m_owner, m_tgt, m_cur_sel, m_cnt;

    always #5 clk = ~clk;

    project_io_sequencer #(.NUM_PROJ(NP), .IO_W(IOW), .GUARD(G)) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .sel_i(sel_i), .sel_valid_i(sel_valid_i),
        .sel_ready_o(sel_ready_o), .disable_i(disable_i), .proj_io_out_i(proj_out),
        .proj_io_oeb_i(proj_oeb), .active_o(active_o), .io_out(io_out), .io_oeb(io_oeb),
        .cur_sel_o(cur_sel_o), .cur_valid_o(cur_valid_o), .err_o(err_o),
        .switch_cnt_o(switch_cnt_o)
    );

    project_io_sequencer #(.NUM_PROJ(NPE), .IO_W(IOWE), .GUARD(GE)) dut_e (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .sel_i(e_sel), .sel_valid_i(e_valid),
        .sel_ready_o(e_ready), .disable_i(1'b0), .proj_io_out_i(e_pout),
        .proj_io_oeb_i(e_poeb), .active_o(e_active), .io_out(e_io_out), .io_oeb(e_io_oeb),
        .cur_sel_o(e_cur_sel), .cur_valid_o(e_cur_valid), .err_o(e_err),
        .switch_cnt_o(e_cnt)
    );

    // ---------------- reference model ----------------
    function automatic int mode_at(int x);
        if (x <= m_drain_until) return M_DRAIN;
        if (x <= m_arm_until)   return M_ARM;
        if (m_owner >= 0)       return M_RUN;
        return M_OFF;
    endfunction

    task automatic model_reset();
        m_e = 0; m_drain_until = -1; m_arm_until = -1;
        m_owner = -1; m_tgt = -1; m_cur_sel = 0; m_cnt = 0;
        x_all = {{NP{1'b0}}, {IOW{1'b0}}, {IOW{1'b1}}, {SW{1'b0}}, 1'b0, 1'b0, 8'd0, 1'b1};
    endtask

    // Predicts the outputs after the next edge from the inputs now applied.
    task automatic model_step();
        int e, pre, post, s;
        logic ready, acc, err;
        logic [NP-1:0]  act;
        logic [IOW-1:0] po, pb;
        e     = m_e + 1;
        pre   = mode_at(e - 1);
        s     = int'(sel_i);
        ready = (pre == M_OFF) || (pre == M_RUN);
        acc   = sel_valid_i && ready && (s < NP);
        err   = sel_valid_i && ready && (s >= NP);
        po = '0; pb = '1;
        if (pre == M_RUN) begin
            po = proj_out[m_owner*IOW +: IOW];
            pb = proj_oeb[m_owner*IOW +: IOW];
        end
        case (pre)
            M_OFF: if (acc) begin m_tgt = s; m_arm_until = e + G - 1; end
            M_RUN: begin
                if (disable_i) begin
                    m_owner = -1; m_tgt = -1;
                    m_drain_until = e + G - 1; m_arm_until = e + G - 1;
                end else if (acc && s != m_owner) begin
                    m_owner = -1; m_tgt = s;
                    m_drain_until = e + G - 1; m_arm_until = e + 2*G - 1;
                end
            end
            M_ARM: begin
                if (disable_i) begin
                    m_tgt = -1; m_drain_until = e + G - 1; m_arm_until = e + G - 1;
                end else if (e > m_arm_until) begin
                    m_owner = m_tgt; m_cur_sel = m_tgt; m_cnt = (m_cnt + 1) % 256;
                end
            end
            default: ;
        endcase
        post = mode_at(e);
        if (!(pre == M_RUN && post == M_RUN)) begin po = '0; pb = '1; end
        act = '0;
        if (post == M_ARM) act[m_tgt] = 1'b1;
        else if (post == M_RUN) act[m_owner] = 1'b1;
        x_all = {act, po, pb, SW'(m_cur_sel), post == M_RUN, err, 8'(m_cnt),
                 (post == M_OFF) || (post == M_RUN)};
        m_e = e;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_proj();
        for (int b = 0; b < NP*IOW; b++) begin
            proj_out[b] = 1'($urandom_range(0, 1));
            proj_oeb[b] = 1'($urandom_range(0, 1));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (obs_all !== x_all) begin n_bad++; $display("FAIL reset_hold got=%h exp=%h", obs_all, x_all); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        n_vec++;
        if (io_oeb !== {IOW{1'b1}} || io_out !== '0 || active_o !== '0 || sel_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL reset_release got oeb=%h out=%h act=%b rdy=%b exp oeb=all1 out=0 act=0 rdy=1",
                              io_oeb, io_out, active_o, sel_ready_o);
        end
        n_vec++;
        if (e_io_oeb !== {IOWE{1'b1}} || e_active !== '0 || e_ready !== 1'b1 || e_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_e got oeb=%h act=%b rdy=%b err=%b", e_io_oeb, e_active, e_ready, e_err);
        end
    endtask

    task automatic test_select_from_off();
        proj_out[2*IOW +: IOW] = PAT2;
        proj_oeb[2*IOW +: IOW] = '0;
        sel_i = 3'd2;
        for (int i = 0; i < 8; i++) begin
            sel_valid_i = (i == 0);
            step();
            n_vec++;
            if (obs_all !== x_all) begin n_bad++; $display("FAIL select_model cyc=%0d got=%h exp=%h", i, obs_all, x_all); end
            n_vec++;
            if (i <= 3 && (active_o !== 8'b00000100 || cur_valid_o !== 1'b0)) begin
                n_bad++; $display("FAIL select_arm cyc=%0d act=%b valid=%b exp act=00000100 valid=0", i, active_o, cur_valid_o);
            end else if (i >= 4 && (cur_valid_o !== 1'b1 || switch_cnt_o !== 8'd1)) begin
                n_bad++; $display("FAIL select_run cyc=%0d valid=%b cnt=%0d exp valid=1 cnt=1", i, cur_valid_o, switch_cnt_o);
            end else if (i >= 5 && (io_out !== PAT2 || io_oeb !== '0)) begin
                n_bad++; $display("FAIL select_pads cyc=%0d out=%h oeb=%h exp out=%h oeb=0", i, io_out, io_oeb, PAT2);
            end
        end
        sel_valid_i = 1'b0;
    endtask

    task automatic test_switch();
        proj_out[5*IOW +: IOW] = PAT5;
        proj_oeb[5*IOW +: IOW] = '0;
        sel_i = 3'd5;
        for (int i = 0; i < 12; i++) begin
            sel_valid_i = (i == 0);
            step();
            n_vec++;
            if (obs_all !== x_all) begin n_bad++; $display("FAIL switch_model cyc=%0d got=%h exp=%h", i, obs_all, x_all); end
            n_vec++;
            if ($countones(active_o) > 1) begin
                n_bad++; $display("FAIL switch_onehot cyc=%0d act=%b exp at most one bit", i, active_o);
            end else if (i <= 3 && (active_o !== '0 || io_oeb !== {IOW{1'b1}} || io_out !== '0)) begin
                n_bad++; $display("FAIL switch_drain cyc=%0d act=%b oeb=%h out=%h exp act=0 oeb=all1 out=0", i, active_o, io_oeb, io_out);
            end else if (i >= 4 && i <= 7 && (active_o !== 8'b00100000 || io_oeb !== {IOW{1'b1}})) begin
                n_bad++; $display("FAIL switch_arm cyc=%0d act=%b oeb=%h exp act=00100000 oeb=all1", i, active_o, io_oeb);
            end else if (i >= 8 && (cur_sel_o !== 3'd5 || cur_valid_o !== 1'b1 || switch_cnt_o !== 8'd2)) begin
                n_bad++; $display("FAIL switch_run cyc=%0d sel=%0d valid=%b cnt=%0d exp 5 1 2", i, cur_sel_o, cur_valid_o, switch_cnt_o);
            end else if (i >= 9 && io_out !== PAT5) begin
                n_bad++; $display("FAIL switch_pads cyc=%0d out=%h exp=%h", i, io_out, PAT5);
            end
        end
        sel_valid_i = 1'b0;
    endtask

    task automatic test_invalid();
        // Repeat select of the current owner: nothing changes.
        sel_i = 3'd5;
        for (int i = 0; i < 3; i++) begin
            sel_valid_i = (i == 0);
            step();
            n_vec++;
            if (obs_all !== x_all || switch_cnt_o !== 8'd2 || cur_valid_o !== 1'b1 || active_o !== 8'b00100000) begin
                n_bad++; $display("FAIL repeat_sel cyc=%0d got=%h exp=%h", i, obs_all, x_all);
            end
        end
        sel_valid_i = 1'b0;
        // Out-of-range on the 6-project instance, first from OFF.
        e_sel = 3'd7; e_valid = 1'b1;
        step();
        e_valid = 1'b0;
        n_vec++;
        if (e_err !== 1'b1 || e_active !== '0 || e_ready !== 1'b1 || e_cur_valid !== 1'b0) begin
            n_bad++; $display("FAIL err_off got err=%b act=%b rdy=%b val=%b exp 1 0 1 0", e_err, e_active, e_ready, e_cur_valid);
        end
        step();
        n_vec++;
        if (e_err !== 1'b0 || e_ready !== 1'b1 || e_active !== '0) begin
            n_bad++; $display("FAIL err_pulse got err=%b rdy=%b act=%b exp 0 1 0", e_err, e_ready, e_active);
        end
        e_sel = 3'd1; e_valid = 1'b1;
        step();
        e_valid = 1'b0;
        n_vec++;
        if (e_active !== 6'b000010 || e_cur_valid !== 1'b0) begin
            n_bad++; $display("FAIL err_arm got act=%b val=%b exp 000010 0", e_active, e_cur_valid);
        end
        step(); step();
        n_vec++;
        if (e_cur_valid !== 1'b1 || e_cur_sel !== 3'd1 || e_cnt !== 8'd1) begin
            n_bad++; $display("FAIL err_run got val=%b sel=%0d cnt=%0d exp 1 1 1", e_cur_valid, e_cur_sel, e_cnt);
        end
        // Out-of-range while running.
        e_sel = 3'd6; e_valid = 1'b1;
        step();
        e_valid = 1'b0;
        n_vec++;
        if (e_err !== 1'b1 || e_cur_valid !== 1'b1 || e_cur_sel !== 3'd1 || e_active !== 6'b000010 || e_cnt !== 8'd1) begin
            n_bad++; $display("FAIL err_run_req got err=%b val=%b sel=%0d act=%b cnt=%0d exp 1 1 1 000010 1",
                              e_err, e_cur_valid, e_cur_sel, e_active, e_cnt);
        end
        step();
        n_vec++;
        if (e_err !== 1'b0 || e_cur_valid !== 1'b1) begin
            n_bad++; $display("FAIL err_run_clear got err=%b val=%b exp 0 1", e_err, e_cur_valid);
        end
    endtask

    task automatic test_disable();
        // disable_i beats a simultaneous select.
        sel_i = 3'd3;
        for (int i = 0; i < 6; i++) begin
            sel_valid_i = (i == 0); disable_i = (i == 0);
            step();
            n_vec++;
            if (obs_all !== x_all) begin n_bad++; $display("FAIL dis_model cyc=%0d got=%h exp=%h", i, obs_all, x_all); end
            n_vec++;
            if (i <= 3 && (active_o !== '0 || cur_valid_o !== 1'b0 || sel_ready_o !== 1'b0 || io_oeb !== {IOW{1'b1}})) begin
                n_bad++; $display("FAIL dis_drain cyc=%0d act=%b val=%b rdy=%b exp 0 0 0", i, active_o, cur_valid_o, sel_ready_o);
            end else if (i >= 4 && (sel_ready_o !== 1'b1 || cur_valid_o !== 1'b0 || active_o !== '0)) begin
                n_bad++; $display("FAIL dis_off cyc=%0d rdy=%b val=%b act=%b exp 1 0 0", i, sel_ready_o, cur_valid_o, active_o);
            end
        end
        // disable_i during ARM restarts the guard and ends in OFF.
        sel_i = 3'd1;
        for (int i = 0; i < 9; i++) begin
            sel_valid_i = (i == 0); disable_i = (i == 2);
            step();
            n_vec++;
            if (obs_all !== x_all) begin n_bad++; $display("FAIL armdis_model cyc=%0d got=%h exp=%h", i, obs_all, x_all); end
            n_vec++;
            if (i >= 2 && i <= 5 && (active_o !== '0 || sel_ready_o !== 1'b0)) begin
                n_bad++; $display("FAIL armdis_drain cyc=%0d act=%b rdy=%b exp 0 0", i, active_o, sel_ready_o);
            end else if (i >= 6 && (sel_ready_o !== 1'b1 || cur_valid_o !== 1'b0 || switch_cnt_o !== 8'd2)) begin
                n_bad++; $display("FAIL armdis_off cyc=%0d rdy=%b val=%b cnt=%0d exp 1 0 2", i, sel_ready_o, cur_valid_o, switch_cnt_o);
            end
        end
        sel_valid_i = 1'b0; disable_i = 1'b0;
    endtask

    task automatic test_reset_mid_arm();
        sel_i = 3'd4; sel_valid_i = 1'b1;
        step();
        sel_valid_i = 1'b0;
        step();
        n_vec++;
        if (active_o !== 8'b00010000) begin n_bad++; $display("FAIL rst_pre_arm act=%b exp 00010000", active_o); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (obs_all !== x_all) begin n_bad++; $display("FAIL rst_mid_arm got=%h exp=%h", obs_all, x_all); end
        n_vec++;
        if (e_cur_valid !== 1'b0 || e_cnt !== 8'd0 || e_active !== '0) begin
            n_bad++; $display("FAIL rst_mid_e val=%b cnt=%0d act=%b exp 0 0 0", e_cur_valid, e_cnt, e_active);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_counter_wrap();
        for (int k = 0; k < 256; k++) begin
            int waited;
            sel_i = SW'(k % 2); sel_valid_i = 1'b1;
            step();
            sel_valid_i = 1'b0;
            waited = 0;
            while (cur_valid_o !== 1'b1 && waited < 3*G) begin
                n_vec++;
                if (obs_all !== x_all) begin n_bad++; $display("FAIL wrap_model sw=%0d got=%h exp=%h", k, obs_all, x_all); end
                step();
                waited++;
            end
            n_vec++;
            if (cur_valid_o !== 1'b1 || obs_all !== x_all) begin
                n_bad++; $display("FAIL wrap_run sw=%0d val=%b got=%h exp=%h", k, cur_valid_o, obs_all, x_all);
            end
            if (k == 254) begin
                n_vec++;
                if (switch_cnt_o !== 8'd255) begin n_bad++; $display("FAIL wrap_255 cnt=%0d exp 255", switch_cnt_o); end
            end
        end
        n_vec++;
        if (switch_cnt_o !== 8'd0) begin n_bad++; $display("FAIL wrap_zero cnt=%0d exp 0", switch_cnt_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            sel_valid_i = ($urandom_range(0, 3) == 0);
            sel_i       = SW'($urandom_range(0, NP - 1));
            disable_i   = ($urandom_range(0, 11) == 0);
            randomize_proj();
            step();
            n_vec++;
            if (obs_all !== x_all) begin n_bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_all, x_all); end
            n_vec++;
            if ($countones(active_o) > 1) begin n_bad++; $display("FAIL random_onehot cyc=%0d act=%b", i, active_o); end
        end
        sel_valid_i = 1'b0; disable_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; sel_i = '0; sel_valid_i = 1'b0; disable_i = 1'b0;
        proj_out = '0; proj_oeb = '1;
        e_sel = '0; e_valid = 1'b0; e_pout = '0; e_poeb = '1;
        test_reset();
        test_select_from_off();
        test_switch();
        test_invalid();
        test_disable();
        test_reset_mid_arm();
        test_counter_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
